// File: rtl/mlp_scheduler.sv
// Sequences one shared combinational perceptron across a 2-2-1 MLP:
// holds the 9-entry weight/bias table and evaluates H0, H1, OUT on consecutive cycles.
module mlp_scheduler #(
  parameter int DATA_W  = 10,
  parameter int HID_ONE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic signed [DATA_W-1:0] cfg_wdata,
  output logic                     cfg_err,
  output logic signed [DATA_W-1:0] pe_x1,
  output logic signed [DATA_W-1:0] pe_x2,
  output logic signed [DATA_W-1:0] pe_w1,
  output logic signed [DATA_W-1:0] pe_w2,
  output logic signed [DATA_W-1:0] pe_bias,
  input  logic                     pe_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     y_out,
  output logic [1:0]               h_out,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, EVAL_H0, EVAL_H1, EVAL_OUT, DONE} state_t;

  localparam logic signed [DATA_W-1:0] HID_V = DATA_W'(HID_ONE);

  state_t                   state, state_nx;
  logic signed [DATA_W-1:0] wt [9];
  logic signed [DATA_W-1:0] xr1, xr2;
  logic [1:0]               h;
  logic                     y;
  logic                     accept, cfg_ok;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign h_out     = h;
  assign y_out     = y;
  assign accept    = in_valid && in_ready;
  assign cfg_ok    = cfg_we && (state == IDLE) && (cfg_addr <= 4'd8);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = EVAL_H0;
      EVAL_H0:  state_nx = EVAL_H1;
      EVAL_H1:  state_nx = EVAL_OUT;
      EVAL_OUT: state_nx = DONE;
      DONE:     if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Table is read combinationally, so a write landing on the accept edge is seen by EVAL_H0.
  always_comb begin
    pe_x1   = '0;
    pe_x2   = '0;
    pe_w1   = '0;
    pe_w2   = '0;
    pe_bias = '0;
    case (state)
      EVAL_H0: begin
        pe_x1 = xr1;    pe_x2 = xr2;
        pe_w1 = wt[0];  pe_w2 = wt[1];  pe_bias = wt[2];
      end
      EVAL_H1: begin
        pe_x1 = xr1;    pe_x2 = xr2;
        pe_w1 = wt[3];  pe_w2 = wt[4];  pe_bias = wt[5];
      end
      EVAL_OUT: begin
        pe_x1 = h[0] ? HID_V : '0;
        pe_x2 = h[1] ? HID_V : '0;
        pe_w1 = wt[6];  pe_w2 = wt[7];  pe_bias = wt[8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      xr1     <= '0;
      xr2     <= '0;
      h       <= '0;
      y       <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < 9; i++) wt[i] <= '0;
    end else begin
      state   <= state_nx;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) wt[cfg_addr] <= cfg_wdata;
      if (accept) begin
        xr1 <= x1;
        xr2 <= x2;
      end
      case (state)
        EVAL_H0:  h[0] <= pe_y;
        EVAL_H1:  h[1] <= pe_y;
        EVAL_OUT: y    <= pe_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_scheduler.sv
// Directed bench for mlp_scheduler with a behavioural step perceptron on the pe_* port.
module tb_mlp_scheduler;
  localparam int DW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0, in_ready;
  logic signed [DW-1:0] x1 = '0, x2 = '0;
  logic                 cfg_we = 1'b0;
  logic [3:0]           cfg_addr = '0;
  logic signed [DW-1:0] cfg_wdata = '0;
  logic                 cfg_err;
  logic signed [DW-1:0] pe_x1, pe_x2, pe_w1, pe_w2, pe_bias;
  logic                 pe_y;
  logic                 out_valid, out_ready = 1'b1, y_out, busy;
  logic [1:0]           h_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [DW-1:0] tw [9];

  always #5 clk = ~clk;

  mlp_scheduler #(.DATA_W(DW), .HID_ONE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .pe_x1(pe_x1), .pe_x2(pe_x2), .pe_w1(pe_w1), .pe_w2(pe_w2),
    .pe_bias(pe_bias), .pe_y(pe_y), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .h_out(h_out), .busy(busy)
  );

  // step perceptron: sum truncated to DW bits, y = sum >= 0
  always_comb begin
    int s;
    logic signed [DW-1:0] st;
    s    = int'(pe_x1) * int'(pe_w1) + int'(pe_x2) * int'(pe_w2) + int'(pe_bias);
    st   = DW'(s);
    pe_y = !st[DW-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic signed [DW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    chk("cfg_ok_noerr", cfg_err, 1'b0);
  endtask

  // Full sample with per-cycle operand checks; leaves the DUT in DONE when rel=0.
  task automatic run(input string tag, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                     input logic [1:0] eh, input logic ey, input bit rel);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    x1 = a; x2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    chk({tag, "_h0_x1"}, pe_x1, a);     chk({tag, "_h0_x2"}, pe_x2, b);
    chk({tag, "_h0_w1"}, pe_w1, tw[0]); chk({tag, "_h0_w2"}, pe_w2, tw[1]);
    chk({tag, "_h0_b"},  pe_bias, tw[2]);
    chk({tag, "_h0_busy"}, {busy, in_ready}, 2'b10);
    tick();
    chk({tag, "_h1_x1"}, pe_x1, a);     chk({tag, "_h1_x2"}, pe_x2, b);
    chk({tag, "_h1_w1"}, pe_w1, tw[3]); chk({tag, "_h1_w2"}, pe_w2, tw[4]);
    chk({tag, "_h1_b"},  pe_bias, tw[5]);
    tick();
    chk({tag, "_o_x1"}, pe_x1, eh[0] ? 10'sd1 : 10'sd0);
    chk({tag, "_o_x2"}, pe_x2, eh[1] ? 10'sd1 : 10'sd0);
    chk({tag, "_o_w1"}, pe_w1, tw[6]); chk({tag, "_o_w2"}, pe_w2, tw[7]);
    chk({tag, "_o_b"},  pe_bias, tw[8]);
    chk({tag, "_o_nv"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_h"}, h_out, eh);
    chk({tag, "_y"}, y_out, ey);
    chk({tag, "_done_pe"}, {pe_x1, pe_w1, pe_bias}, '0);
    if (rel) begin
      out_ready = 1'b1;
      tick();
      chk({tag, "_ret"}, {out_valid, in_ready, busy}, 3'b010);
    end
  endtask

  task automatic load_xor();
    tw[0] = 2;  tw[1] = 2;  tw[2] = -1;
    tw[3] = -2; tw[4] = -2; tw[5] = 3;
    tw[6] = 2;  tw[7] = 2;  tw[8] = -3;
    for (int i = 0; i < 9; i++) cfg_write(4'(i), tw[i]);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) tw[i] = '0;

    // reset values
    #12;
    chk("rst_outs", {out_valid, cfg_err, y_out, h_out, busy}, '0);
    chk("rst_pe", {pe_x1, pe_x2, pe_w1, pe_w2, pe_bias}, '0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1'b1);

    // zero table: every sum is 0 -> all ones
    run("zero", 0, 0, 2'b11, 1'b1, 1'b1);

    // XOR network, h_out = {H1,H0}
    load_xor();
    run("xor00", 0, 0, 2'b10, 1'b0, 1'b1);
    run("xor01", 0, 1, 2'b11, 1'b1, 1'b1);
    run("xor10", 1, 0, 2'b11, 1'b1, 1'b1);
    run("xor11", 1, 1, 2'b01, 1'b0, 1'b1);

    // backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    run("bp", 1, 1, 2'b01, 1'b0, 1'b0);
    x1 = 0; x2 = 1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_hold", {out_valid, y_out, h_out, in_ready}, 5'b10010);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // dropped config writes
    x1 = 1; x2 = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 10'sd7;
    tick();
    cfg_we = 1'b0;
    chk("busy_err", cfg_err, 1'b1);
    tick();
    chk("busy_err_clr", cfg_err, 1'b0);
    chk("busy_res", {out_valid, h_out, y_out}, 4'b1111);
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_wdata = 10'sd7;
    tick();
    cfg_we = 1'b0;
    chk("addr_err", cfg_err, 1'b1);
    tick();
    chk("addr_err_clr", cfg_err, 1'b0);
    run("post_err", 0, 1, 2'b11, 1'b1, 1'b1);

    // write on the accept edge is used by EVAL_H0
    tw[0] = 10'sd5;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 10'sd5;
    run("wr_acc", 0, 0, 2'b10, 1'b0, 1'b1);
    chk("wr_acc_err", cfg_err, 1'b0);

    // reset during EVAL_OUT
    x1 = 1; x2 = 1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_eval", {busy, pe_w1}, {1'b1, 10'sd2});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {out_valid, busy, cfg_err}, 3'b000);
    chk("mid_rst_pe", {pe_x1, pe_x2, pe_w1, pe_w2, pe_bias}, '0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) tw[i] = '0;
    tick();
    chk("post_rst_ready", {in_ready, out_valid}, 2'b10);
    run("post_rst", 1, 1, 2'b11, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
